// File: rtl/button_conditioner.sv
// Debounce, edge-detect and auto-repeat for the inc/mode/sel clock-set keys.
// Raw keys are synchronised, normalised to 1=pressed and run through per-key FSMs.
module button_conditioner #(
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned HOLD_TICKS     = 600,
  parameter int unsigned REPEAT_TICKS   = 150,
  parameter logic [2:0]  REPEAT_MASK    = 3'b001,
  parameter bit          ACTIVE_LOW     = 1'b1
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [2:0] keys_raw,
  output logic       btinc_pulse,
  output logic       btmode_pulse,
  output logic       btsel_pulse,
  output logic [2:0] btn_level
);

  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW   = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_TICKS - 1);
  localparam logic [2:0]    REL_LVL   = ACTIVE_LOW ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } state_e;

  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] s;

  // Reset loads the released level so a key held through reset is a fresh press.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= keys_raw;
      sync2_q <= sync1_q;
    end
  end

  assign s = ACTIVE_LOW ? ~sync2_q : sync2_q;

  logic [TW-1:0] tick_q;
  logic [TW-1:0] tick_d;
  logic          tick;

  assign tick   = (tick_q == TICK_LAST);
  assign tick_d = tick ? '0 : tick_q + 1'b1;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) tick_q <= '0;
    else             tick_q <= tick_d;
  end

  logic [2:0] pulse;
  logic [2:0] level;

  for (genvar i = 0; i < 3; i++) begin : g_ch
    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic [HW-1:0] hold_lim;
    logic          rep_q;
    logic          rep_d;
    logic          pulse_q;
    logic          pulse_d;
    logic          lvl_q;
    logic          lvl_d;
    logic          db_done;
    logic          hold_hit;

    assign db_done  = tick && (cnt_q == DB_LAST);
    assign hold_lim = rep_q ? REP_LAST : HOLD_LAST;
    assign hold_hit = REPEAT_MASK[i] && tick && (hold_q == hold_lim);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        hold_q  <= '0;
        rep_q   <= 1'b0;
        pulse_q <= 1'b0;
        lvl_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hold_q  <= hold_d;
        rep_q   <= rep_d;
        pulse_q <= pulse_d;
        lvl_q   <= lvl_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      rep_d   = rep_q;
      unique case (state_q)
        IDLE: begin
          if (s[i]) begin
            state_d = PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s[i]) begin
            state_d = IDLE;
          end else if (db_done) begin
            state_d = HELD;
            hold_d  = '0;
            rep_d   = 1'b0;
          end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!s[i]) begin
            state_d = REL_WAIT;
            cnt_d   = '0;
          end else if (hold_hit) begin
            hold_d = '0;
            rep_d  = 1'b1;
          end else if (tick && hold_q != hold_lim) begin
            // Without repeat, hold parks at its limit instead of wrapping.
            hold_d = hold_q + 1'b1;
          end
        end
        REL_WAIT: begin
          if (s[i]) begin
            state_d = HELD;
          end else if (db_done) begin
            state_d = IDLE;
          end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_comb begin
      pulse_d = 1'b0;
      lvl_d   = lvl_q;
      unique case (state_q)
        PRESS_WAIT: begin
          if (s[i] && db_done) begin
            pulse_d = 1'b1;
            lvl_d   = 1'b1;
          end
        end
        HELD: begin
          if (s[i] && hold_hit) pulse_d = 1'b1;
        end
        REL_WAIT: begin
          if (!s[i] && db_done) lvl_d = 1'b0;
        end
        default: ;
      endcase
    end

    assign pulse[i] = pulse_q;
    assign level[i] = lvl_q;
  end

  assign btinc_pulse  = pulse[0];
  assign btmode_pulse = pulse[1];
  assign btsel_pulse  = pulse[2];
  assign btn_level    = level;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with small timing parameters.
// Outputs are sampled 1 time unit after each rising clock edge.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] keys;
  logic       inc_p;
  logic       mode_p;
  logic       sel_p;
  logic [2:0] lvl;

  always #5 clk = ~clk;

  button_conditioner #(
    .TICK_DIV      (4),
    .DEBOUNCE_TICKS(3),
    .HOLD_TICKS    (8),
    .REPEAT_TICKS  (2),
    .REPEAT_MASK   (3'b001),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .keys_raw    (keys),
    .btinc_pulse (inc_p),
    .btmode_pulse(mode_p),
    .btsel_pulse (sel_p),
    .btn_level   (lvl)
  );

  int n_checks = 0;
  int n_errors = 0;
  int k;
  int cnt [3];
  int first_k [3];
  int consec;
  int lvl_high;
  int lvl_miss;
  int drop_k;
  int ptimes[$];
  logic [2:0] prev_p;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int in_range(input int v, input int lo, input int hi);
    return (v >= lo && v <= hi) ? 1 : 0;
  endfunction

  task automatic clear_stats();
    k        = 0;
    consec   = 0;
    lvl_high = 0;
    lvl_miss = 0;
    drop_k   = -1;
    ptimes.delete();
    for (int c = 0; c < 3; c++) begin
      cnt[c]     = 0;
      first_k[c] = -1;
    end
  endtask

  task automatic run(input int n);
    logic [2:0] p;
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      k++;
      p = {sel_p, mode_p, inc_p};
      if ((p & prev_p) != 3'b000) consec++;
      prev_p = p;
      for (int c = 0; c < 3; c++) begin
        if (p[c]) begin
          cnt[c]++;
          if (first_k[c] < 0) first_k[c] = k;
          if (!lvl[c]) lvl_miss++;
        end
      end
      if (p[0]) ptimes.push_back(k);
      if (lvl != 3'b000) lvl_high++;
      if (!lvl[0] && drop_k < 0) drop_k = k;
    end
  endtask

  initial begin
    int bad_gap;
    rst    = 1'b1;
    keys   = 3'b111;
    prev_p = 3'b000;
    clear_stats();

    repeat (3) @(posedge clk);
    #1;
    check("reset_level", int'(lvl), 0);
    check("reset_pulses", int'({sel_p, mode_p, inc_p}), 0);

    rst = 1'b0;
    clear_stats();
    run(200);
    check("idle_pulses", cnt[0] + cnt[1] + cnt[2], 0);
    check("idle_level_cycles", lvl_high, 0);

    clear_stats();
    keys[0] = 1'b0;
    run(40);
    check("inc_count", cnt[0], 1);
    check("inc_latency_11_15", in_range(first_k[0], 11, 15), 1);
    check("inc_level_with_pulse", lvl_miss, 0);
    check("inc_level_held", int'(lvl), 1);
    check("inc_other_pulses", cnt[1] + cnt[2], 0);

    clear_stats();
    keys[0] = 1'b1;
    run(40);
    check("inc_release_11_15", in_range(drop_k, 11, 15), 1);
    check("inc_release_pulses", cnt[0] + cnt[1] + cnt[2], 0);

    clear_stats();
    for (int b = 0; b < 10; b++) begin
      keys[1] = b[0];
      run(3);
    end
    check("bounce_pulses", cnt[1], 0);
    keys[1] = 1'b0;
    run(40);
    check("bounce_then_press", cnt[1], 1);
    keys[1] = 1'b1;
    run(40);

    clear_stats();
    keys[0] = 1'b0;
    run(120);
    check("repeat_count", ptimes.size(), 11);
    if (ptimes.size() >= 3) begin
      check("repeat_first_gap", ptimes[1] - ptimes[0], 32);
      bad_gap = 0;
      for (int i = 2; i < ptimes.size(); i++)
        if (ptimes[i] - ptimes[i-1] != 8) bad_gap++;
      check("repeat_gaps_8", bad_gap, 0);
    end
    check("repeat_no_consecutive", consec, 0);
    clear_stats();
    keys[0] = 1'b1;
    run(40);
    check("repeat_after_release", cnt[0], 0);

    clear_stats();
    keys[2] = 1'b0;
    run(120);
    check("sel_single_pulse", cnt[2], 1);
    check("sel_level_held", int'(lvl), 4);
    keys[2] = 1'b1;
    run(40);
    check("sel_level_released", int'(lvl), 0);

    clear_stats();
    keys = 3'b010;
    run(30);
    check("sim_inc_count", cnt[0], 1);
    check("sim_sel_count", cnt[2], 1);
    check("sim_mode_count", cnt[1], 0);
    check("sim_same_cycle", first_k[0] - first_k[2], 0);
    check("sim_level", int'(lvl), 5);

    rst = 1'b1;
    #1;
    check("async_reset_level", int'(lvl), 0);
    check("async_reset_pulses", int'({sel_p, mode_p, inc_p}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    prev_p = 3'b000;
    clear_stats();
    run(30);
    check("post_reset_inc", cnt[0], 1);
    check("post_reset_sel", cnt[2], 1);
    check("post_reset_mode", cnt[1], 0);
    check("post_reset_latency", in_range(first_k[0], 11, 15), 1);
    check("post_reset_same_cycle", first_k[0] - first_k[2], 0);
    keys = 3'b111;
    run(40);
    check("final_level", int'(lvl), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end conditioner for the three clock-setting pushbuttons (increment, mode, select) that feed the Nios II system's btinc/btmode/btsel PIO inputs.
- Converts raw, bouncing, asynchronous key levels into clean single-cycle press events, with auto-repeat on held keys.
- The firmware no longer polls or debounces.
- Sits between the board keys and the system instance, in the same clock domain.

Parameters:
- TICK_DIV, 50000: clock cycles per timing tick (1 ms at 50 MHz).
- DEBOUNCE_TICKS, 20: ticks of stable level required to accept a press or a release.
- HOLD_TICKS, 600: ticks held after the accepted press before the first auto-repeat event.
- REPEAT_TICKS, 150: ticks between subsequent auto-repeat events.
- REPEAT_MASK, 3'b001: per-channel auto-repeat enable (bit0 inc, bit1 mode, bit2 sel).
- ACTIVE_LOW, 1: 1 means raw keys read 0 when pressed.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- keys_raw  in  3  raw key pins: bit0 inc, bit1 mode, bit2 sel. Asynchronous to clk_clk.
- btinc_pulse  out  1  one-cycle event for accepted inc press or auto-repeat.
- btmode_pulse  out  1  one-cycle event for accepted mode press or auto-repeat.
- btsel_pulse  out  1  one-cycle event for accepted sel press or auto-repeat.
- btn_level  out  3  debounced pressed level per channel, active-high.

Behaviour:
- Clock and reset: one clock, clk_clk; reset_reset is asynchronous and active-high.
- Reset values:
  - All pulses and btn_level are 0.
  - Tick counter is 0.
  - Every channel is in IDLE with its counters at 0.
  - Synchronizer flops load the released level (1 if ACTIVE_LOW).
- Synchronizer: two flops per bit, then polarity normalisation to s[i] (1 = pressed). Latency is 2 cycles.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick is high for exactly one cycle when the counter equals TICK_DIV-1.
  - The tick is free-running and shared by all channels.
- Per-channel FSM (the three channels are fully independent):
  - IDLE:
    - s=1 moves to PRESS_WAIT with cnt=0.
  - PRESS_WAIT:
    - s=0 returns to IDLE with no event (bounce rejected).
    - Otherwise cnt increments on each tick.
    - On the tick where cnt==DEBOUNCE_TICKS-1: move to HELD, assert the press pulse next cycle, set btn_level=1, set hold=0, set phase=first.
  - HELD:
    - s=0 moves to REL_WAIT with cnt=0.
    - Otherwise hold increments on each tick.
    - If REPEAT_MASK[i] is set:
      - phase first: when hold reaches HOLD_TICKS, pulse, reset hold to 0, set phase=repeat.
      - phase repeat: pulse each time hold reaches REPEAT_TICKS, then reset hold to 0.
    - If REPEAT_MASK[i] is clear, hold saturates and no further pulses occur.
  - REL_WAIT:
    - s=1 returns to HELD, with hold and phase preserved and no new press event.
    - Otherwise cnt increments on each tick.
    - On the tick where cnt==DEBOUNCE_TICKS-1: move to IDLE and set btn_level=0.
    - No event is generated on release.
- Timing and width rules:
  - Debounce acceptance takes between (DEBOUNCE_TICKS-1)*TICK_DIV+1 and DEBOUNCE_TICKS*TICK_DIV cycles after s rises, depending on tick alignment.
  - Pulse outputs are registered, one cycle wide, and never asserted on consecutive cycles.
  - Counters are sized by $clog2 of their limits and never wrap unintentionally.
- Boundary conditions:
  - Simultaneous presses on several channels each produce their own pulse, possibly in the same cycle.
  - A key held through reset deassertion is seen as released by the reset synchronizer state. It then produces a fresh press event after normal sync and debounce.
  - Reset asserted mid-operation forces all outputs to 0 immediately (asynchronously). No partial pulse is emitted.
  - Any glitch shorter than one full debounce window never produces an event.

Test Plan:
Use TICK_DIV=4, DEBOUNCE_TICKS=3, HOLD_TICKS=8, REPEAT_TICKS=2, REPEAT_MASK=3'b001, ACTIVE_LOW=1 throughout.
1. Reset idle: assert reset_reset, then release with keys_raw=3'b111 for 200 cycles -> all pulses 0 and btn_level=3'b000 throughout.
2. Clean inc press: keys_raw[0] falls and is held 40 cycles -> exactly one btinc_pulse, 11-15 cycles after the edge. btn_level[0]=1 in the same cycle. After release, btn_level[0] returns to 0 within 11-15 cycles, with no pulse.
3. Bounce rejection: keys_raw[1] toggles every 3 cycles for 30 cycles, then holds low 40 cycles -> no pulse during bouncing, then exactly one btmode_pulse.
4. Auto-repeat: hold keys_raw[0] low for 120 cycles -> initial pulse, then next pulse exactly 32 cycles later, then pulses every 8 cycles until release. After release, no further pulses.
5. No repeat on mode/sel: hold keys_raw[2] low for 120 cycles -> exactly one btsel_pulse.
6. Simultaneity and reset: press inc and sel on the same cycle -> btinc_pulse and btsel_pulse in the same cycle. Then assert reset_reset mid-hold -> outputs 0 immediately. Release reset with the keys still held -> each pressed channel pulses once again after 11-15 cycles.
